sad_best_mv: RTL

- Downstream consumer of the motion-estimation load/shift sequencer.
- Each cycle it takes one aligned row pair: a current-block row (CPR) and a search-window row (SPR).
- It computes the sum of absolute differences (SAD) for each candidate position and keeps the minimum-SAD motion vector across the whole search.
- It reports the best MV and its SAD to the mode-decision stage when the search completes.

---
 rtl/sad_best_mv_pkg.sv | 33 +++
 rtl/sad_best_mv_if.sv | 46 ++++
 rtl/sad_best_mv_sad_row.sv | 31 +++
 rtl/sad_best_mv.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sad_best_mv_pkg.sv
// Shared constants and types for the SAD best-motion-vector search block.
//   PIXW/SIZE/MVXW/MVYW/SADW : pixel, block, MV and SAD widths
//   ROWW                     : width of one row sum (PIXW + clog2(SIZE))
//   state_e                  : search FSM states
//   tag_t                    : per-row side information carried down the pipeline
package sad_best_mv_pkg;

  localparam int unsigned PIXW    = 8;
  localparam int unsigned SIZE    = 16;
  localparam int unsigned MVXW    = 4;
  localparam int unsigned MVYW    = 5;
  localparam int unsigned SADW    = 16;
  localparam int unsigned ROWW    = PIXW + $clog2(SIZE);
  localparam int unsigned CNTW    = $clog2(SIZE) + 1;
  localparam int unsigned ROWBITS = SIZE * PIXW;

  localparam logic [SADW-1:0] SAD_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic            last;
    logic            first;
    logic [MVXW-1:0] mvx;
    logic [MVYW-1:0] mvy;
  } tag_t;

endpackage

// File: rtl/sad_best_mv_if.sv
// Row-stream and result bundle between the ME sequencer (master) and
// sad_best_mv (slave).
//   inputs to the block : start, row_valid, cpr_row, spr_row, row_last,
//                         cand_last, mv_x, mv_y
//   outputs             : busy, cand_valid, cand_sad, done, best_sad,
//                         best_mvx, best_mvy, row_err
//   SAD_EARLY_TERM_EN   : adds output cand_skip
interface sad_best_mv_if import sad_best_mv_pkg::*; ();

  logic               start;
  logic               row_valid;
  logic [ROWBITS-1:0] cpr_row;
  logic [ROWBITS-1:0] spr_row;
  logic               row_last;
  logic               cand_last;
  logic [MVXW-1:0]    mv_x;
  logic [MVYW-1:0]    mv_y;
  logic               busy;
  logic               cand_valid;
  logic [SADW-1:0]    cand_sad;
  logic               done;
  logic [SADW-1:0]    best_sad;
  logic [MVXW-1:0]    best_mvx;
  logic [MVYW-1:0]    best_mvy;
  logic               row_err;
`ifdef SAD_EARLY_TERM_EN
  logic               cand_skip;
`endif

  modport master (
`ifdef SAD_EARLY_TERM_EN
    input  cand_skip,
`endif
    output start, row_valid, cpr_row, spr_row, row_last, cand_last, mv_x, mv_y,
    input  busy, cand_valid, cand_sad, done, best_sad, best_mvx, best_mvy, row_err
  );

  modport slave (
`ifdef SAD_EARLY_TERM_EN
    output cand_skip,
`endif
    input  start, row_valid, cpr_row, spr_row, row_last, cand_last, mv_x, mv_y,
    output busy, cand_valid, cand_sad, done, best_sad, best_mvx, best_mvy, row_err
  );

endinterface

// File: rtl/sad_best_mv_sad_row.sv
// Combinational row SAD helper.
//   i_cpr, i_spr -> o_absdiff : per-pixel |cpr - spr|, pixel 0 in LSBs
//   i_absdiff    -> o_row_sum : sum of SIZE absolute differences
// The two halves are split so the caller can register between them.
module sad_row import sad_best_mv_pkg::*; (
  input  logic [ROWBITS-1:0] i_cpr,
  input  logic [ROWBITS-1:0] i_spr,
  output logic [ROWBITS-1:0] o_absdiff,
  input  logic [ROWBITS-1:0] i_absdiff,
  output logic [ROWW-1:0]    o_row_sum
);

  // per-pixel absolute difference
  always_comb begin
    o_absdiff = '0;
    for (int i = 0; i < int'(SIZE); i++) begin
      o_absdiff[i*PIXW +: PIXW] = (i_cpr[i*PIXW +: PIXW] >= i_spr[i*PIXW +: PIXW]) ?
                                  (i_cpr[i*PIXW +: PIXW] - i_spr[i*PIXW +: PIXW]) :
                                  (i_spr[i*PIXW +: PIXW] - i_cpr[i*PIXW +: PIXW]);
    end
  end

  // zero-extended row sum
  always_comb begin
    o_row_sum = '0;
    for (int i = 0; i < int'(SIZE); i++) begin
      o_row_sum = o_row_sum + ROWW'(i_absdiff[i*PIXW +: PIXW]);
    end
  end

endmodule

// File: rtl/sad_best_mv.sv
// Minimum-SAD motion vector search over a stream of aligned row pairs.
//   clk, reset : clock, asynchronous active-low reset
//   bus        : sad_best_mv_if.slave (row stream in, per-candidate SAD and
//                best MV out)
// Pipeline: S1 abs-diff regs, S2 row sum, S3 candidate accumulator; cand_valid
// is 3 cycles after the row_last input cycle, the best compare one cycle later.
// Optional SAD_EARLY_TERM_EN adds cand_skip when a partial SAD already reaches
// the current best.
module sad_best_mv import sad_best_mv_pkg::*; (
  input logic          clk,
  input logic          reset,
  sad_best_mv_if.slave bus
);

  state_e             r_state;
  logic [1:0]         r_flush_cnt;
  logic               r_busy;
  logic               r_done;
  logic [CNTW-1:0]    r_row_cnt;
  logic               r_row_err;

  logic [ROWBITS-1:0] r_s1_diff;
  logic               r_s1_valid;
  tag_t               r_s1_tag;
  logic [ROWW-1:0]    r_s2_sum;
  logic               r_s2_valid;
  tag_t               r_s2_tag;
  logic [SADW-1:0]    r_acc;
  logic               r_cand_valid;
  logic [SADW-1:0]    r_cand_sad;
  logic [MVXW-1:0]    r_cand_mvx;
  logic [MVYW-1:0]    r_cand_mvy;
  logic               r_cand_term;

  logic [SADW-1:0]    r_best_sad;
  logic [MVXW-1:0]    r_best_mvx;
  logic [MVYW-1:0]    r_best_mvy;

  logic [ROWBITS-1:0] w_absdiff;
  logic [ROWW-1:0]    w_row_sum;
  logic               w_accept;
  logic [CNTW-1:0]    w_cnt_base;
  logic               w_first;
  logic               w_len_bad;
  logic [SADW-1:0]    w_new_acc;
  logic               w_term_ok;

  sad_row u_sad_row (
    .i_cpr     (bus.cpr_row),
    .i_spr     (bus.spr_row),
    .o_absdiff (w_absdiff),
    .i_absdiff (r_s1_diff),
    .o_row_sum (w_row_sum)
  );

  // a start cycle always restarts the row count, so its row becomes row 0
  assign w_accept   = bus.row_valid & (bus.start | (r_state == RUN));
  assign w_cnt_base = bus.start ? '0 : r_row_cnt;
  assign w_first    = (w_cnt_base == '0);
  assign w_len_bad  = w_accept & bus.row_last &
                      ((w_cnt_base + CNTW'(1)) != CNTW'(SIZE)) & ~w_term_ok;
  assign w_new_acc  = r_s2_tag.first ? SADW'(r_s2_sum) : (r_acc + SADW'(r_s2_sum));

`ifdef SAD_EARLY_TERM_EN
  logic r_skip;
  logic r_skipped;
  logic r_term_ok;
  logic w_skipped_eff;
  logic w_skip_hit;

  assign w_skipped_eff = r_s2_tag.first ? 1'b0 : r_skipped;
  assign w_skip_hit    = r_s2_valid & ~r_s2_tag.last & ~w_skipped_eff &
                         (w_new_acc >= r_best_sad);
  assign w_term_ok     = r_term_ok & ~bus.start;
  assign bus.cand_skip = r_skip;

  // skip pulse and termination bookkeeping, one pulse per candidate
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_skip      <= 1'b0;
      r_skipped   <= 1'b0;
      r_term_ok   <= 1'b0;
      r_cand_term <= 1'b0;
    end else begin
      r_skip <= w_skip_hit & ~bus.start;
      if (bus.start) begin
        r_skipped <= 1'b0;
      end else if (r_s2_valid) begin
        r_skipped <= r_s2_tag.last ? 1'b0 : (w_skipped_eff | w_skip_hit);
      end
      if (r_s2_valid & r_s2_tag.last) begin
        r_cand_term <= w_skipped_eff;
      end
      if (bus.start | (w_accept & bus.row_last)) begin
        r_term_ok <= 1'b0;
      end else if (w_skip_hit) begin
        r_term_ok <= 1'b1;
      end
    end
  end
`else
  assign w_term_ok   = 1'b0;
  assign r_cand_term = 1'b0;
`endif

  // search FSM with registered busy/done
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_flush_cnt <= 2'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else if (bus.start) begin
      r_state     <= RUN;
      r_flush_cnt <= 2'd0;
      r_busy      <= 1'b1;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: r_busy <= 1'b0;
        RUN: begin
          if (w_accept & bus.row_last & bus.cand_last) begin
            r_state     <= FLUSH;
            r_flush_cnt <= 2'd0;
          end
        end
        FLUSH: begin
          if (r_flush_cnt == 2'd2) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_flush_cnt <= r_flush_cnt + 2'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // row counter and sticky length error
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_row_cnt <= '0;
      r_row_err <= 1'b0;
    end else begin
      if (w_accept) begin
        if (bus.row_last) begin
          r_row_cnt <= '0;
        end else if (w_cnt_base != '1) begin
          r_row_cnt <= w_cnt_base + CNTW'(1);
        end else begin
          r_row_cnt <= w_cnt_base;
        end
      end else if (bus.start) begin
        r_row_cnt <= '0;
      end
      if (bus.start) begin
        r_row_err <= w_len_bad;
      end else if (w_len_bad) begin
        r_row_err <= 1'b1;
      end
    end
  end

  // S1..S3 datapath; start drops everything already in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_diff    <= '0;
      r_s1_valid   <= 1'b0;
      r_s1_tag     <= '0;
      r_s2_sum     <= '0;
      r_s2_valid   <= 1'b0;
      r_s2_tag     <= '0;
      r_acc        <= '0;
      r_cand_valid <= 1'b0;
      r_cand_sad   <= '0;
      r_cand_mvx   <= '0;
      r_cand_mvy   <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_diff <= w_absdiff;
        r_s1_tag  <= '{last: bus.row_last, first: w_first, mvx: bus.mv_x, mvy: bus.mv_y};
      end
      r_s2_valid <= r_s1_valid & ~bus.start;
      if (r_s1_valid) begin
        r_s2_sum <= w_row_sum;
        r_s2_tag <= r_s1_tag;
      end
      r_cand_valid <= r_s2_valid & r_s2_tag.last & ~bus.start;
      if (r_s2_valid) begin
        r_acc <= w_new_acc;
        if (r_s2_tag.last) begin
          r_cand_sad <= w_new_acc;
          r_cand_mvx <= r_s2_tag.mvx;
          r_cand_mvy <= r_s2_tag.mvy;
        end
      end
    end
  end

  // running minimum; strict compare keeps the earlier candidate on ties
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_best_sad <= SAD_MAX;
      r_best_mvx <= '0;
      r_best_mvy <= '0;
    end else if (bus.start) begin
      r_best_sad <= SAD_MAX;
      r_best_mvx <= '0;
      r_best_mvy <= '0;
    end else if (r_cand_valid & ~r_cand_term & (r_cand_sad < r_best_sad)) begin
      r_best_sad <= r_cand_sad;
      r_best_mvx <= r_cand_mvx;
      r_best_mvy <= r_cand_mvy;
    end
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.cand_valid = r_cand_valid;
  assign bus.cand_sad   = r_cand_sad;
  assign bus.best_sad   = r_best_sad;
  assign bus.best_mvx   = r_best_mvx;
  assign bus.best_mvy   = r_best_mvy;
  assign bus.row_err    = r_row_err;

endmodule
